i2c_target_regs: RTL
====================

# i2c_target_regs

I2C target (responder) with a 256-byte register-access port. Sits behind an `iic_buffer` instance in open-collector mode, where `iic_scl_o` is tied 1 and `iic_scl_t` is tied 1. It decodes START, STOP, address and R/W from the synchronised bus lines and drives SDA open-drain for ACK and read data. Each accepted byte is turned into a single-cycle write or read strobe on a local register interface, with an auto-incrementing pointer.

## Interface
- `I2C_ADDR`, default 7'h50: 7-bit target address.
- `FILTER_LEN`, default 3: number of consecutive identical synchronised samples required before a line change is accepted (1..7).
- `clk` input 1: system clock; must be ≥ 20× the SCL frequency.
- `rstn` input 1: asynchronous, active-low reset.
- `iic_scl_i` input 1: SCL from the buffer; asynchronous.
- `iic_sda_i` input 1: SDA from the buffer; asynchronous.
- `iic_sda_o` output 1: constant 0.
- `iic_sda_t` output 1: 1 releases SDA, 0 pulls SDA low.
- `reg_addr` output 8: current register pointer.
- `reg_wdata` output 8: write data; valid while `reg_we` is high.
- `reg_we` output 1: single-cycle write strobe.
- `reg_re` output 1: single-cycle read strobe.
- `reg_rdata` input 8: read data; sampled exactly 1 cycle after `reg_re`.
- `busy` output 1: high from an addressed START until STOP.

## Operation
- Input path:
  - Each line passes through a 2-flop synchroniser, then a glitch filter of length FILTER_LEN.
  - Filtered values only are used below, written SCLf and SDAf.
  - Edge detects: `scl_rise`, `scl_fall`.
- Bus condition detection:
  - START: SDAf falls while SCLf is high.
  - STOP: SDAf rises while SCLf is high.
  - Both override every state.
  - START moves to ADDR with bit counter 7 and releases SDA.
  - STOP moves to IDLE and releases SDA.
- Data bits are sampled on `scl_rise`, MSB first. SDA output changes only in the cycle after `scl_fall`.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RD_ACK, WAIT_STOP.
- ADDR:
  - After 8 bits, if bits[7:1] == I2C_ADDR: go to ADDR_ACK, set `busy`, and drive ACK (sda_t=0) after `scl_fall`.
  - On mismatch: go to WAIT_STOP with SDA released (NACK).
- ADDR_ACK:
  - Write (R/W=0): release SDA on the `scl_fall` ending the ACK, then go to PTR.
  - Read (R/W=1): pulse `reg_re` on the ACK-slot `scl_rise`, load `reg_rdata` into the shift register the next cycle, drive bit 7 on `scl_fall`, then go to RDATA.
- PTR: the 8 bits received load the pointer. ACK, then go to WDATA.
- WDATA:
  - Set `reg_wdata` and pulse `reg_we` for 1 cycle, starting the cycle after the 8th bit is sampled, with `reg_addr` = pointer.
  - Pointer increments the following cycle, wrapping 8'hFF→8'h00.
  - Always ACK, then return to WDATA.
- RDATA: shift out 8 bits. After the 8th `scl_fall`, release SDA and increment the pointer (wraps the same way). Go to RD_ACK.
- RD_ACK:
  - Controller ACK (SDAf=0 at `scl_rise`): pulse `reg_re` and reload, as in ADDR_ACK, then go to RDATA.
  - NACK: go to WAIT_STOP.
- WAIT_STOP: SDA released; bus ignored until START or STOP.
- The pointer persists across transactions. A write of the pointer only, followed by a repeated START with read, reads from that pointer.
- There is no clock stretching and no general-call support.

## Timing
- Reset values: `iic_sda_t`=1, `iic_sda_o`=0, `reg_addr`=0, `reg_wdata`=0, `reg_we`=0, `reg_re`=0, `busy`=0, state=IDLE, filters=1.
- Input latency, bus line to filtered edge: 2 + FILTER_LEN cycles.
- SDA drive update: 1 cycle after `scl_fall` detection.
- `reg_re` → `reg_rdata` capture: exactly 1 cycle. Register reads must be combinational or 1-cycle registered.
- `reg_we` and `reg_re` never assert in the same cycle, and never outside PTR/WDATA/ADDR_ACK/RD_ACK.
- `busy` clears on STOP or on address mismatch.
- `rstn` asserted mid-transfer immediately releases SDA. After deassertion the block waits in IDLE for the next START.
- A START or STOP during a bit or ACK slot aborts the byte with no `reg_we`.

## Structure
- Package `i2c_pkg`: the state enum `i2c_tgt_state_t` and the constants `I2C_ACK`=0, `I2C_NACK`=1 and `I2C_RW_READ`=1.
- Sub-module `i2c_line_filter` (synchroniser + FILTER_LEN filter + rise/fall outputs), instantiated for SCL and for SDA.

## Test plan
- Write 0x50/W, pointer 0x10, data 0xA5, 0x3C, STOP → ACK on all 4 bytes; `reg_we` at addr 0x10 with 0xA5, then at 0x11 with 0x3C; `busy` low after STOP.
- Write 0x50/W, pointer 0x20, repeated START, 0x50/R, read 3 bytes with ACK,ACK,NACK, where the model returns addr^0xFF → `reg_re` at 0x20, 0x21, 0x22; SDA bytes 0xDF, 0xDE, 0xDD; SDA released after the 3rd byte.
- Address 0x51/W → NACK; no strobes; SDA stays released until STOP; `busy`=0.
- Pointer 0xFF, write 0x11, 0x22 → writes at 0xFF then 0x00.
- 1-cycle SDA glitch while SCL is high, with FILTER_LEN=3 → no START/STOP detected and the transfer continues.
- `rstn` pulsed during the address ACK slot → `iic_sda_t`=1 within the reset cycle; the next full write transfer completes correctly.

Source files
------------

// File: rtl/i2c_target_regs_pkg.sv
// Shared types and bus constants for the I2C register target.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RD_ACK,
    WAIT_STOP
  } i2c_tgt_state_t;

  localparam logic I2C_ACK     = 1'b0;
  localparam logic I2C_NACK    = 1'b1;
  localparam logic I2C_RW_READ = 1'b1;

endpackage

// File: rtl/i2c_target_regs_if.sv
// Local register-access port: the I2C target is the master of this bus.
interface i2c_target_regs_if;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;

  modport master (output reg_addr, reg_wdata, reg_we, reg_re, input reg_rdata);
  modport slave  (input reg_addr, reg_wdata, reg_we, reg_re, output reg_rdata);
endinterface

// File: rtl/i2c_line_filter.sv
// Two-flop synchroniser plus run-length glitch filter with edge pulses
// aligned to the cycle the filtered value changes.
module i2c_line_filter #(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rstn,
  input  logic line_i,
  output logic filt_o,
  output logic rise_o,
  output logic fall_o
);

  logic       sync1_q, sync2_q, filt_q, filt_d;
  logic       rise_q, rise_d, fall_q, fall_d;
  logic [2:0] cnt_q, cnt_d;

  // cnt_q counts consecutive samples disagreeing with the filtered value
  always_comb begin
    filt_d = filt_q;
    cnt_d  = 3'd0;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (sync2_q != filt_q) begin
      if (cnt_q == 3'(FILTER_LEN - 1)) begin
        filt_d = sync2_q;
        rise_d = sync2_q;
        fall_d = !sync2_q;
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      filt_q  <= 1'b1;
      cnt_q   <= 3'd0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= line_i;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign filt_o = filt_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with an auto-incrementing 8-bit pointer into a 256-byte
// register space; SDA is driven open-drain through iic_sda_t.
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0]  I2C_ADDR   = 7'h50,
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              iic_scl_i,
  input  logic              iic_sda_i,
  output logic              iic_sda_o,
  output logic              iic_sda_t,
  output logic              busy,
  i2c_target_regs_if.master rif
);

  logic scl_f, scl_rise, scl_fall, sda_f, sda_rise, sda_fall;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk(clk), .rstn(rstn), .line_i(iic_scl_i),
    .filt_o(scl_f), .rise_o(scl_rise), .fall_o(scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk(clk), .rstn(rstn), .line_i(iic_sda_i),
    .filt_o(sda_f), .rise_o(sda_rise), .fall_o(sda_fall)
  );

  i2c_tgt_state_t state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d, ptr_q, ptr_d, wdata_q, wdata_d;
  logic       we_q, we_d, re_q, re_d, cap_q;
  logic       ack_on_q, ack_on_d, rw_q, rw_d, sda_t_q, sda_t_d, busy_q, busy_d;
  logic       start_c, stop_c, last_bit, addr_match, rd_mode;
  logic [7:0] byte_c;

  assign start_c    = sda_fall && scl_f;
  assign stop_c     = sda_rise && scl_f;
  assign last_bit   = (bit_cnt_q == 3'd0);
  assign byte_c     = {shift_q[6:0], sda_f};
  assign addr_match = (byte_c[7:1] == I2C_ADDR);
  assign rd_mode    = (rw_q == I2C_RW_READ);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start_c) begin
      state_d = ADDR;
    end else if (stop_c) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        ADDR:      if (scl_rise && last_bit) state_d = addr_match ? ADDR_ACK : WAIT_STOP;
        ADDR_ACK:  if (scl_fall && ack_on_q) state_d = rd_mode ? RDATA : PTR;
        PTR:       if (scl_rise && last_bit) state_d = PTR_ACK;
        PTR_ACK:   if (scl_fall && ack_on_q) state_d = WDATA;
        WDATA:     if (scl_rise && last_bit) state_d = WDATA_ACK;
        WDATA_ACK: if (scl_fall && ack_on_q) state_d = WDATA;
        RDATA:     if (scl_fall && last_bit) state_d = RD_ACK;
        RD_ACK: begin
          if (scl_rise && !ack_on_q && sda_f == I2C_NACK) state_d = WAIT_STOP;
          else if (scl_fall && ack_on_q)                  state_d = RDATA;
        end
        default: ;
      endcase
    end
  end

  // ack_on_q marks that the ACK slot proper has begun (first fall seen)
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = cap_q ? rif.reg_rdata : shift_q;
    ptr_d     = we_q ? ptr_q + 8'd1 : ptr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    re_d      = 1'b0;
    ack_on_d  = ack_on_q;
    rw_d      = rw_q;
    sda_t_d   = sda_t_q;
    busy_d    = busy_q;
    if (start_c) begin
      bit_cnt_d = 3'd7;
      sda_t_d   = 1'b1;
      ack_on_d  = 1'b0;
    end else if (stop_c) begin
      sda_t_d  = 1'b1;
      ack_on_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        ADDR, PTR, WDATA: begin
          if (scl_rise) begin
            shift_d   = byte_c;
            bit_cnt_d = bit_cnt_q - 3'd1;
            if (last_bit) begin
              ack_on_d = 1'b0;
              if (state_q == ADDR) begin
                rw_d   = sda_f;
                busy_d = addr_match;
              end
              if (state_q == PTR) ptr_d = byte_c;
              if (state_q == WDATA) begin
                we_d    = 1'b1;
                wdata_d = byte_c;
              end
            end
          end
        end
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          if (scl_fall && !ack_on_q) begin
            sda_t_d  = I2C_ACK;
            ack_on_d = 1'b1;
          end else if (scl_fall) begin
            ack_on_d  = 1'b0;
            bit_cnt_d = 3'd7;
            sda_t_d   = (state_q == ADDR_ACK && rd_mode) ? shift_q[7] : 1'b1;
          end
          if (scl_rise && ack_on_q && state_q == ADDR_ACK && rd_mode) re_d = 1'b1;
        end
        RDATA: begin
          if (scl_fall && last_bit) begin
            sda_t_d = 1'b1;
            ptr_d   = ptr_q + 8'd1;
          end else if (scl_fall) begin
            sda_t_d   = shift_q[6];
            shift_d   = {shift_q[6:0], 1'b1};
            bit_cnt_d = bit_cnt_q - 3'd1;
          end
        end
        RD_ACK: begin
          if (scl_rise && !ack_on_q && sda_f == I2C_ACK) begin
            re_d     = 1'b1;
            ack_on_d = 1'b1;
          end else if (scl_fall && ack_on_q) begin
            sda_t_d   = shift_q[7];
            ack_on_d  = 1'b0;
            bit_cnt_d = 3'd7;
          end
        end
        default: sda_t_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bit_cnt_q <= 3'd7;
      ptr_q     <= 8'd0;
      wdata_q   <= 8'd0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      cap_q     <= 1'b0;
      ack_on_q  <= 1'b0;
      rw_q      <= 1'b0;
      sda_t_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      ptr_q     <= ptr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      re_q      <= re_d;
      cap_q     <= re_q;
      ack_on_q  <= ack_on_d;
      rw_q      <= rw_d;
      sda_t_q   <= sda_t_d;
      busy_q    <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign iic_sda_o     = 1'b0;
  assign iic_sda_t     = sda_t_q;
  assign busy          = busy_q;
  assign rif.reg_addr  = ptr_q;
  assign rif.reg_wdata = wdata_q;
  assign rif.reg_we    = we_q;
  assign rif.reg_re    = re_q;

endmodule
